// File: rtl/piano_pkg.sv
// piano_pkg: shared definitions for the song sequencer.
//   - note code constants (rest, M1, end-of-song marker)
//   - sequencer state enum
//   - key-to-code offset and the free-play key priority encoder
package piano_pkg;

    localparam int NOTE_REST = 0;
    localparam int NOTE_M1   = 8;
    localparam int NOTE_END  = 31;

    // key bit i maps to note code KEY_OFS + i + 1 ... i.e. bit0 -> M1
    localparam int KEY_OFS = NOTE_M1 - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_GAP,
        ST_PAUSED,
        ST_DONE
    } state_t;

    // Lowest set key bit wins; no key gives code 0. Bit i yields KEY_OFS+1+i,
    // so bit0 (M1) -> 8 ... bit6 (M7) -> 14.
    function automatic logic [4:0] key_to_code(input logic [6:0] key);
        logic [4:0] code;
        code = 5'd0;
        for (int i = 6; i >= 0; i--) begin
            if (key[i]) code = 5'(KEY_OFS + 1 + i);
        end
        return code;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// beat_timer: loadable down counter shared by the PLAY and GAP phases.
//   clk, rst_n  : clock, async active-low reset
//   load        : load load_val this cycle (overrides enable)
//   load_val    : value to load
//   en          : count down by one (held low while paused)
//   one_flag    : counter currently equals 1 (last cycle of a phase)
module beat_timer
    import piano_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             one_flag
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   count <= '0;
        else if (load)                count <= load_val;
        else if (en && count != '0)   count <= count - 1'b1;
    end

    assign one_flag = (count == CNT_W'(1));

endmodule

// File: rtl/song_sequencer_ctrl.sv
// song_sequencer_ctrl: shares one tone generator between free keyboard play
// and ROM-driven auto-play with start / pause / resume.
//   mode        : 0 free play, 1 auto play
//   song_sel    : song index, latched on start_pulse
//   start_pulse : (re)start the latched song at step 0
//   pause_pulse : toggle pause while a note or gap is running
//   key         : debounced keys, bit0 = M1 .. bit6 = M7
//   rom_addr    : {song, step} to a synchronous song ROM (1-cycle latency)
//   rom_note    : note code (0 rest, 31 end marker); rom_beats: length, 0 = 1
//   tone_code / tone_en : to the tone generator
//   busy        : sequencing (FETCH, PLAY, GAP, PAUSED)
//   step_done   : pulse after the final gap cycle of each step
// Build option: AUTO_LOOP_EN -- end marker or step wrap restarts the song at
// step 0 instead of stopping in DONE.
module song_sequencer_ctrl
    import piano_pkg::*;
#(
    parameter int BEAT_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int STEP_W      = 6,
    parameter int NOTE_W      = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [1:0]          song_sel,
    input  logic                start_pulse,
    input  logic                pause_pulse,
    input  logic [6:0]          key,
    output logic [2+STEP_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0]   rom_note,
    input  logic [2:0]          rom_beats,
    output logic [NOTE_W-1:0]   tone_code,
    output logic                tone_en,
    output logic                busy,
    output logic                step_done
);

    // Wide enough for 7 * BEAT_CYCLES without truncation.
    localparam int CNT_W = 3 + $clog2(BEAT_CYCLES);

    state_t              state, state_nx, held, held_nx, play_nx;
    logic                fetch_ph, fetch_ph_nx;
    logic [1:0]          song, song_nx;
    logic [STEP_W-1:0]   step, step_nx;
    logic [NOTE_W-1:0]   note, note_nx;
    logic [NOTE_W-1:0]   tone_code_nx;
    logic                tone_en_nx, step_done_nx, busy_nx;
    logic                t_load, t_en, t_one;
    logic [CNT_W-1:0]    t_val;
    logic [2:0]          beats_eff;
    logic [CNT_W-1:0]    play_len;

    assign rom_addr  = {song, step};
    assign beats_eff = (rom_beats == 3'd0) ? 3'd1 : rom_beats;
    // The gap is carved out of the note's tail, so the step keeps its length.
    assign play_len  = CNT_W'(beats_eff) * CNT_W'(BEAT_CYCLES) - CNT_W'(GAP_CYCLES);

    beat_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .one_flag (t_one)
    );

    always_comb begin
        state_nx     = state;
        held_nx      = held;
        play_nx      = ST_PLAY;
        fetch_ph_nx  = 1'b0;
        song_nx      = song;
        step_nx      = step;
        note_nx      = note;
        tone_code_nx = tone_code;
        tone_en_nx   = 1'b0;
        step_done_nx = 1'b0;
        t_load       = 1'b0;
        t_val        = CNT_W'(GAP_CYCLES);
        t_en         = (state == ST_PLAY) || (state == ST_GAP);

        if (!mode) begin
            // Free play overrides everything, including a running song.
            state_nx     = ST_IDLE;
            tone_code_nx = NOTE_W'(key_to_code(key));
            tone_en_nx   = |key;
        end else if (start_pulse) begin
            state_nx = ST_FETCH;
            song_nx  = song_sel;
            step_nx  = '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph_nx = 1'b1;            // ROM read in flight
                    end else if (rom_note == NOTE_W'(NOTE_END)) begin
`ifdef AUTO_LOOP_EN
                        step_nx  = '0;
                        state_nx = ST_FETCH;
`else
                        state_nx = ST_DONE;
`endif
                    end else begin
                        t_load       = 1'b1;
                        t_val        = play_len;
                        note_nx      = rom_note;
                        tone_code_nx = rom_note;
                        tone_en_nx   = (rom_note != NOTE_W'(NOTE_REST));
                        state_nx     = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (t_one) begin
                        t_load  = 1'b1;
                        play_nx = ST_GAP;
                    end
                    // The pause cycle itself still counts as played.
                    if (pause_pulse) begin
                        held_nx  = play_nx;
                        state_nx = ST_PAUSED;
                    end else begin
                        state_nx   = play_nx;
                        tone_en_nx = (play_nx == ST_PLAY) && (note != NOTE_W'(NOTE_REST));
                    end
                end
                ST_GAP: begin
                    // Step completion takes priority over a pause on the last gap cycle.
                    if (t_one) begin
                        step_done_nx = 1'b1;
`ifdef AUTO_LOOP_EN
                        step_nx  = step + 1'b1;        // wraps to 0
                        state_nx = ST_FETCH;
`else
                        if (&step) begin
                            state_nx = ST_DONE;
                        end else begin
                            step_nx  = step + 1'b1;
                            state_nx = ST_FETCH;
                        end
`endif
                    end else if (pause_pulse) begin
                        held_nx  = ST_GAP;
                        state_nx = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (pause_pulse) begin
                        state_nx   = held;
                        tone_en_nx = (held == ST_PLAY) && (note != NOTE_W'(NOTE_REST));
                    end
                end
                default: ;                              // IDLE, DONE wait for start/mode
            endcase
        end

        busy_nx = (state_nx == ST_FETCH) || (state_nx == ST_PLAY) ||
                  (state_nx == ST_GAP)   || (state_nx == ST_PAUSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            held      <= ST_PLAY;
            fetch_ph  <= 1'b0;
            song      <= '0;
            step      <= '0;
            note      <= '0;
            tone_code <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state     <= state_nx;
            held      <= held_nx;
            fetch_ph  <= fetch_ph_nx;
            song      <= song_nx;
            step      <= step_nx;
            note      <= note_nx;
            tone_code <= tone_code_nx;
            tone_en   <= tone_en_nx;
            busy      <= busy_nx;
            step_done <= step_done_nx;
        end
    end

endmodule

// File: tb/tb_song_sequencer_ctrl.sv
// Bench for song_sequencer_ctrl with BEAT_CYCLES=10, GAP_CYCLES=2.
// A step-position model predicts every output each cycle; directed scenarios
// pin the model with hand-computed counts; a random phase follows.
module tb_song_sequencer_ctrl;

    localparam int B = 10;
    localparam int G = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       mode = 1'b0, start_pulse = 1'b0, pause_pulse = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic [6:0] key = 7'd0;
    logic [7:0] rom_addr;
    logic [4:0] rom_note = 5'd0;
    logic [2:0] rom_beats = 3'd0;
    logic [4:0] tone_code;
    logic       tone_en, busy, step_done;

    logic [4:0] note_mem  [256];
    logic [2:0] beats_mem [256];

    int checks = 0, failures = 0;

    song_sequencer_ctrl #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .STEP_W(6), .NOTE_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .song_sel(song_sel),
        .start_pulse(start_pulse), .pause_pulse(pause_pulse), .key(key),
        .rom_addr(rom_addr), .rom_note(rom_note), .rom_beats(rom_beats),
        .tone_code(tone_code), .tone_en(tone_en), .busy(busy), .step_done(step_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_note  <= note_mem[rom_addr];
        rom_beats <= beats_mem[rom_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos is the cycle index inside the current step: 0,1 fetch, then
    // play, then G gap cycles; a step lasts beats*B+2 cycles.
    bit         m_free, m_act, m_paused, m_sd;
    int         m_pos, m_len;
    logic [1:0] m_song;
    logic [5:0] m_step;
    logic [4:0] m_note;
    logic [6:0] m_key;

    function automatic logic [4:0] key_code(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 5'(8 + i);
        return 5'd0;
    endfunction

    task automatic model_reset();
        m_free = 0; m_act = 0; m_paused = 0; m_sd = 0;
        m_pos = 0; m_len = 0; m_song = 0; m_step = 0; m_note = 0; m_key = 0;
    endtask

    task automatic song_end();
`ifdef AUTO_LOOP_EN
        m_step = 0; m_pos = 0;
`else
        m_act = 0;
`endif
    endtask

    task automatic model_step();
        int n, b;
        m_sd = 0;
        if (!mode) begin
            m_free = 1; m_act = 0; m_paused = 0; m_key = key;
        end else if (start_pulse) begin
            m_free = 0; m_act = 1; m_paused = 0; m_song = song_sel; m_step = 0; m_pos = 0;
        end else begin
            m_free = 0;
            if (m_act) begin
                if (m_paused) begin
                    if (pause_pulse) m_paused = 0;
                end else if (m_pos == 0) begin
                    m_pos = 1;
                end else if (m_pos == 1) begin
                    n = int'(note_mem[{m_song, m_step}]);
                    if (n == 31) song_end();
                    else begin
                        b = int'(beats_mem[{m_song, m_step}]);
                        if (b == 0) b = 1;
                        m_note = 5'(n); m_len = b * B + 2; m_pos = 2;
                    end
                end else if (m_pos == m_len - 1) begin
                    m_sd = 1;
                    if (m_step == 6'd63) song_end();
                    else begin m_step = m_step + 1; m_pos = 0; end
                end else begin
                    if (pause_pulse) m_paused = 1;
                    m_pos++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_on = 0;
    initial forever begin
        logic exp_en;
        @(negedge clk);
        if (rst_n && chk_on) begin
            exp_en = m_free ? (|m_key)
                            : (m_act && !m_paused && m_pos >= 2 && m_pos < m_len - G && m_note != 0);
            chk("busy", busy, m_act);
            chk("tone_en", tone_en, exp_en);
            chk("step_done", step_done, m_sd);
            if (m_free)      chk("tone_code_free", tone_code, key_code(m_key));
            else if (exp_en) chk("tone_code_play", tone_code, m_note);
            if (m_act)       chk("rom_addr", rom_addr, {m_song, m_step});
        end
    end

    // ---------------- activity counters ----------------
    bit mon_on = 0;
    int mon_hi = 0, mon_sd = 0, mon_busy = 0;
    initial forever begin
        @(negedge clk);
        #1;
        if (mon_on) begin
            if (tone_en)   mon_hi++;
            if (step_done) mon_sd++;
            if (busy)      mon_busy++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mon_start();
        mon_hi = 0; mon_sd = 0; mon_busy = 0; mon_on = 1;
    endtask

    task automatic pulse_start(input logic [1:0] s);
        song_sel = s; start_pulse = 1; cyc(1); start_pulse = 0; cyc(1);
    endtask

    task automatic wait_en(input logic lvl, input int budget, input string name);
        int n = 0;
        while (tone_en !== lvl && n < budget) begin cyc(1); n++; end
        chk(name, tone_en, lvl);
    endtask

    task automatic rand_song(input int s);
        for (int i = 0; i < 64; i++) begin
            note_mem[s*64+i]  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 21));
            beats_mem[s*64+i] = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] addrs[$];
        for (int s = 0; s < 3; s++) rand_song(s);
        for (int i = 192; i < 256; i++) begin
            note_mem[i] = 5'($urandom_range(0, 21)); beats_mem[i] = 3'd1;
        end

        // reset state
        cyc(3);
        chk("rst_tone_en", tone_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_tone_code", tone_code, 0);
        chk("rst_step_done", step_done, 0);
        #2 rst_n = 1;
        chk_on = 1;
        cyc(1);

        // free play passthrough
        key = 7'b0010100; cyc(1);
        chk("free_code_M3", tone_code, 10);
        chk("free_en", tone_en, 1);
        key = 7'b0000000; cyc(1);
        chk("free_nokey_en", tone_en, 0);
        chk("free_nokey_code", tone_code, 0);

        // song 1: {8,2} {0,1} {END}
        note_mem[64] = 8;  beats_mem[64] = 2;
        note_mem[65] = 0;  beats_mem[65] = 1;
        note_mem[66] = 31; beats_mem[66] = 0;
        mode = 1; cyc(1);
        mon_start();
        pulse_start(2'd1);
        repeat (45) begin
            if (busy && (addrs.size() == 0 || addrs[addrs.size()-1] != rom_addr))
                addrs.push_back(rom_addr);
            cyc(1);
        end
        mon_on = 0;
        chk("song1_sd_count", mon_sd, 2);
        chk("song1_addr0", addrs[0], 8'h40);
        chk("song1_addr1", addrs[1], 8'h41);
        chk("song1_addr2", addrs[2], 8'h42);
`ifdef AUTO_LOOP_EN
        chk("song1_loop_addr", addrs[3], 8'h40);
        chk("song1_loop_busy", busy, 1);
`else
        chk("song1_hi_count", mon_hi, 18);
        chk("song1_busy_count", mon_busy, 36);
        chk("song1_done_busy", busy, 0);
`endif

        // pause 5 cycles into PLAY, resume 50 cycles later
        note_mem[128] = 8; beats_mem[128] = 2;
        note_mem[129] = 31;
        mon_start();
        pulse_start(2'd2);
        wait_en(1, 10, "pause_wait_play");
        cyc(4); pause_pulse = 1; cyc(1); pause_pulse = 0;
        chk("paused_tone_en", tone_en, 0);
        chk("paused_busy", busy, 1);
        cyc(49); pause_pulse = 1; cyc(1); pause_pulse = 0;
        chk("resumed_tone_en", tone_en, 1);
        cyc(30);
        mon_on = 0;
`ifndef AUTO_LOOP_EN
        chk("pause_hi_count", mon_hi, 18);
        chk("pause_busy_count", mon_busy, 74);
`endif

        // start + pause together mid-GAP of step 1, then mode drop mid-PLAY
        note_mem[0] = 9;  beats_mem[0] = 1;
        note_mem[1] = 10; beats_mem[1] = 1;
        note_mem[2] = 31;
        pulse_start(2'd0);
        wait_en(1, 10, "sp_wait_play0");
        wait_en(0, 20, "sp_wait_gap0");
        wait_en(1, 10, "sp_wait_play1");
        wait_en(0, 20, "sp_wait_gap1");
        chk("sp_addr_before", rom_addr, 8'h01);
        start_pulse = 1; pause_pulse = 1; cyc(1); start_pulse = 0; pause_pulse = 0;
        chk("sp_restart_addr", rom_addr, 8'h00);
        chk("sp_restart_busy", busy, 1);
        cyc(2);
        chk("sp_not_paused", tone_en, 1);
        chk("sp_code", tone_code, 9);
        cyc(3);
        key = 7'b0000001; mode = 0; cyc(1);
        chk("abort_busy", busy, 0);
        chk("abort_tone_en", tone_en, 1);
        chk("abort_code", tone_code, 8);
        key = 0; mode = 1; cyc(1);

        // asynchronous reset mid-PLAY
        pulse_start(2'd0);
        wait_en(1, 10, "rst_wait_play");
        cyc(3);
        #2 rst_n = 0;
        #1;
        chk("midrst_tone_en", tone_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", rom_addr, 0);
        cyc(1);
        #2 rst_n = 1;
        cyc(1);

        // song 3 has no END: 64 one-beat steps, then wrap behaviour
        mon_start();
        pulse_start(2'd3);
        cyc(771);
        mon_on = 0;
        chk("wrap_sd_count", mon_sd, 64);
`ifdef AUTO_LOOP_EN
        chk("wrap_loop_busy", busy, 1);
        chk("wrap_loop_addr", rom_addr, 8'hC0);
`else
        chk("wrap_done_busy", busy, 0);
`endif

        // random phase
        mode = 0; cyc(2);
        for (int s = 0; s < 3; s++) rand_song(s);
        mode = 1;
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 999);
            start_pulse = 0; pause_pulse = 0;
            if (r < 8) begin
                start_pulse = 1;
                song_sel = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            end else if (r < 30) begin
                pause_pulse = 1;
            end else if (r < 33 && mode) begin
                mode = 0;
            end else if (r < 120 && !mode) begin
                mode = 1;
            end
            if ($urandom_range(0, 19) == 0) key = 7'($urandom_range(0, 127));
            cyc(1);
        end
        start_pulse = 0; pause_pulse = 0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
